// File: rtl/mul_div_hilo.sv
// Iterative multiply/divide unit that owns the HI/LO registers, with MTHI/MTLO writes.
// Optional MUL_EARLY_TERM_EN: a multiply stops iterating once the remaining multiplier bits are all zero.
module mul_div_hilo #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] in3,
  input  logic        we_hi,
  input  logic        we_lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          is_div, neg_p, neg_r, dz;
  logic [63:0]   acc, mcand;
  logic [31:0]   mplier;

  logic        op_signed, start_dz, early;
  logic [31:0] mag1, mag2;
  logic [32:0] trial;
  logic [33:0] diff;
  logic        ge;
  logic [63:0] mul_neg;

  assign op_signed = op[0];
  assign start_dz  = op[1] && (in2 == 32'd0);
  assign mag1      = (op_signed && in1[31]) ? -in1 : in1;
  assign mag2      = (op_signed && in2[31]) ? -in2 : in2;

  // Restoring divide: acc[63:32] is the partial remainder, acc[31:0] shifts dividend out / quotient in.
  assign trial   = {acc[63:32], acc[31]};
  assign diff    = {1'b0, trial} - {2'b00, mcand[31:0]};
  assign ge      = ~diff[33];
  assign mul_neg = -acc;

`ifdef MUL_EARLY_TERM_EN
  assign early = !is_div && (mplier[31:1] == 31'd0);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = start_dz ? FIX : CALC;
      CALC:    if (cnt == CW'(ITER - 1) || early) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (we_hi) hi <= in3;
          if (we_lo) lo <= in3;
          if (start) begin
            cnt    <= '0;
            is_div <= op[1];
            dz     <= start_dz;
            neg_p  <= op_signed && (in1[31] ^ in2[31]);
            neg_r  <= op_signed && in1[31];
            if (op[1]) begin
              acc    <= {32'd0, mag1};
              mcand  <= {32'd0, mag2};
              mplier <= '0;
            end else begin
              acc    <= '0;
              mcand  <= {32'd0, mag1};
              mplier <= mag2;
            end
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            acc <= {(ge ? diff[31:0] : trial[31:0]), acc[30:0], ge};
          end else begin
            acc    <= acc + (mplier[0] ? mcand : 64'd0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        FIX: begin
          done <= 1'b1;
          if (dz) begin
            div_zero <= 1'b1;
          end else if (is_div) begin
            lo <= neg_p ? -acc[31:0]  : acc[31:0];
            hi <= neg_r ? -acc[63:32] : acc[63:32];
          end else begin
            hi <= neg_p ? mul_neg[63:32] : acc[63:32];
            lo <= neg_p ? mul_neg[31:0]  : acc[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_hilo.sv
// Directed bench for mul_div_hilo: vector table plus hand sequences for
// divide-by-zero, ignored inputs while busy, MTHI, and asynchronous reset.
module tb_mul_div_hilo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] in1 = '0, in2 = '0, in3 = '0;
  logic        we_hi = 1'b0, we_lo = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mul_div_hilo dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .in1(in1), .in2(in2), .in3(in3), .we_hi(we_hi), .we_lo(we_lo),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected start-to-done edge count.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
    logic [31:0] m;
    int k;
    if (o[1]) return (b == 32'd0) ? 1 : 33;
`ifdef MUL_EARLY_TERM_EN
    m = (o[0] && b[31]) ? -b : b;
    k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) k = i;
    return k + 2;
`else
    m = b;
    k = 0;
    return 33 + k + int'(m[0] & 1'b0);
`endif
  endfunction

  task automatic wait_done(input string nm, input int n0, input int elat);
    int n;
    bit got;
    n = n0;
    got = (done === 1'b1);
    while (!got && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (done === 1'b1) got = 1;
    end
    check({nm, ":latency"}, n, elat);
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    @(negedge clock);
    start = 1'b1; op = o; in1 = a; in2 = b;
    @(posedge clock); #1;
    start = 1'b0;
    check({nm, ":busy_e0"}, busy, 1);
    check({nm, ":done_e0"}, done, 0);
    wait_done(nm, 0, exp_lat(o, b));
    check({nm, ":hi"}, hi, ehi);
    check({nm, ":lo"}, lo, elo);
    check({nm, ":div_zero"}, div_zero, edz);
    check({nm, ":busy_done"}, busy, 0);
  endtask

  initial begin
    int n;
    int seen;

    vecs[0] = '{"multu_max",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult_neg",   2'b01, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6};
    vecs[2] = '{"div_neg",    2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu",       2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{"div_ovf",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{"mult_min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[6] = '{"multu_one",  2'b00, 32'h12345678, 32'h00000001, 32'h00000000, 32'h12345678};
    vecs[7] = '{"div_negdiv", 2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{"multu_zero", 2'b00, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};

    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst:hi", hi, 0);
    check("rst:lo", lo, 0);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:div_zero", div_zero, 0);
    @(negedge clock) reset = 1'b0;

    // Each op starts in the previous op's done cycle (back-to-back).
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0);

    // MTHI/MTLO preload, then divide by zero leaves HI/LO untouched.
    @(negedge clock); we_hi = 1'b1; in3 = 32'h11111111;
    @(negedge clock); we_hi = 1'b0; we_lo = 1'b1; in3 = 32'h22222222;
    @(negedge clock); we_lo = 1'b0;
    check("mt:hi", hi, 32'h11111111);
    check("mt:lo", lo, 32'h22222222);
    run_op("divu_zero", 2'b10, 32'd5, 32'd0, 32'h11111111, 32'h22222222, 1'b1);
    run_op("div_zero",  2'b11, 32'hFFFFFFFB, 32'd0, 32'h11111111, 32'h22222222, 1'b1);

    // start and MTLO during a multiply must be ignored.
    @(negedge clock);
    start = 1'b1; op = 2'b00; in1 = 32'd3; in2 = 32'h80000005;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    start = 1'b1; op = 2'b10; in1 = 32'd1; in2 = 32'd0; we_lo = 1'b1; in3 = 32'hDEADBEEF;
    @(posedge clock); #1;
    start = 1'b0; we_lo = 1'b0;
    check("ign:busy_e10", busy, 1);
    wait_done("ign", 10, 33);
    check("ign:hi", hi, 32'h00000001);
    check("ign:lo", lo, 32'h8000000F);
    check("ign:div_zero", div_zero, 0);

    @(negedge clock); we_hi = 1'b1; in3 = 32'h12345678;
    @(posedge clock); #1;
    we_hi = 1'b0;
    check("mthi:hi", hi, 32'h12345678);
    check("mthi:lo", lo, 32'h8000000F);

    // Asynchronous reset in the middle of a divide.
    @(negedge clock);
    start = 1'b1; op = 2'b11; in1 = 32'hFFFFFFF9; in2 = 32'd2;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst:hi", hi, 0);
    check("arst:lo", lo, 0);
    check("arst:busy", busy, 0);
    @(negedge clock) reset = 1'b0;
    seen = 0;
    n = 0;
    while (n < 40) begin
      @(posedge clock); #1;
      n++;
      if (done === 1'b1) seen++;
    end
    check("arst:no_done", seen, 0);
    check("arst:hi_after", hi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
